// File: rtl/trng_req_arbiter_pkg.sv
// Shared types for the TRNG request arbiter: FSM state encoding and counter sizing.
package trng_pkg;

    typedef enum logic [2:0] {
        WARMUP,
        IDLE,
        GEN,
        SAMPLE,
        DELIVER
    } state_e;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/trng_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or after ptr, wrapping.
// Zero latency; no backpressure (pure function of req and ptr).
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   pos;
    logic [IW-1:0] cand;

    // Scan from the farthest candidate back to ptr so the nearest set bit wins.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        pos  = '0;
        cand = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + (IW + 1)'(i);
            if (pos >= (IW + 1)'(N)) begin
                pos = pos - (IW + 1)'(N);
            end
            cand = pos[IW-1:0];
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trng_req_arbiter.sv
// Round-robin sharing of one TRNG: warm-up discard, STRIDE enable cycles per word, gnt at t+STRIDE+2.
// Requesters hold req until gnt; a dropped request forfeits its word. TRNG_HEALTH_EN adds a repetition test.
module trng_req_arbiter
    import trng_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int NUM_REQ       = 4,
    parameter int STRIDE        = 32,
    parameter int WARMUP_CYCLES = 64,
    parameter int REP_LIMIT     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [WIDTH-1:0]   rnd_data,
    output logic               ready,
    output logic               trng_en,
    input  logic [WIDTH-1:0]   trng_data,
    output logic               health_fail
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = cnt_width(STRIDE, WARMUP_CYCLES);
    localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP_CYCLES - 1);
    localparam logic [CW-1:0] GEN_LAST  = CW'(STRIDE - 1);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_chk_req
        $error("NUM_REQ must be 2..16");
    end
    if (STRIDE < 1 || WARMUP_CYCLES < 1) begin : g_chk_cnt
        $error("STRIDE and WARMUP_CYCLES must be >= 1");
    end
    if (REP_LIMIT < 2) begin : g_chk_rep
        $error("REP_LIMIT must be >= 2");
    end

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic [WIDTH-1:0]   rnd_q, rnd_d;
    logic               en_q, en_d;
    logic               ready_q, ready_d;
    logic               hfail_q, hfail_d;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               health_trip;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef TRNG_HEALTH_EN
    localparam int RW = $clog2(REP_LIMIT + 1);

    logic [RW-1:0]    rep_q, rep_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_vld_q, prev_vld_d;

    always_comb begin
        rep_d       = rep_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        health_trip = 1'b0;
        if (state_q == SAMPLE) begin
            prev_d     = trng_data;
            prev_vld_d = 1'b1;
            if (prev_vld_q && (trng_data == prev_q)) begin
                if (rep_q != RW'(REP_LIMIT)) begin
                    rep_d = rep_q + RW'(1);
                end
            end else begin
                rep_d = RW'(1);
            end
            health_trip = (rep_d == RW'(REP_LIMIT));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q      <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            rep_q      <= rep_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
        end
    end
`else
    assign health_trip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        word_d  = word_q;
        rnd_d   = rnd_q;
        ready_d = ready_q;
        hfail_d = hfail_q;
        gnt     = '0;
        case (state_q)
            // Count only cycles the TRNG was actually enabled; the first post-reset cycle is not.
            WARMUP: begin
                if (en_q) begin
                    if (cnt_q == WARM_LAST) begin
                        cnt_d   = '0;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            IDLE: begin
                if (pick_any && !hfail_q) begin
                    idx_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = GEN;
                end
            end
            GEN: begin
                if (cnt_q == GEN_LAST) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SAMPLE: begin
                word_d = trng_data;
                if (health_trip) begin
                    hfail_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                if (req[idx_q]) begin
                    gnt[idx_q] = 1'b1;
                    rnd_d      = word_q;
                end
                ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + IW'(1);
                state_d = IDLE;
            end
            default: state_d = WARMUP;
        endcase
        en_d = (state_d == WARMUP) || (state_d == GEN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WARMUP;
            cnt_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            rnd_q   <= '0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            hfail_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            rnd_q   <= rnd_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            hfail_q <= hfail_d;
        end
    end

    assign rnd_data    = rnd_d;
    assign ready       = ready_q;
    assign trng_en     = en_q;
    assign health_fail = hfail_q;

endmodule

// File: tb/tb_trng_req_arbiter.sv
// Bench for trng_req_arbiter: LFSR TRNG stub, directed requests, queue-based grant scoreboard.
module tb_trng_req_arbiter;

    localparam int NUM_REQ = 4;
    localparam logic [31:0] SEED  = 32'hACE1BEEF;
    localparam logic [31:0] CONST = 32'h12345678;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [31:0] rnd_data;
    logic        ready;
    logic        trng_en;
    logic [31:0] trng_data;
    logic        health_fail;

    logic [31:0] lfsr_q;
    logic        const_mode;
    int          cyc;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [3:0]  g;
        logic [31:0] d;
        int          c;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    trng_req_arbiter #(
        .WIDTH(32), .NUM_REQ(NUM_REQ), .STRIDE(2), .WARMUP_CYCLES(4), .REP_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .rnd_data(rnd_data),
        .ready(ready), .trng_en(trng_en), .trng_data(trng_data), .health_fail(health_fail)
    );

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [31:0] lfsr_n(input int n);
        logic [31:0] s;
        s = SEED;
        for (int k = 0; k < n; k++) s = lfsr_step(s);
        return s;
    endfunction

    // TRNG stub: registered output, advances once per enabled cycle.
    always @(posedge clk) begin
        if (rst) lfsr_q <= SEED;
        else if (trng_en) lfsr_q <= lfsr_step(lfsr_q);
    end
    assign trng_data = const_mode ? CONST : lfsr_q;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (gnt !== 4'b0000) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_gnt: got gnt=%b, required none (cycle %0d)", gnt, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("gnt", gnt, e.g);
                check("rnd_data", rnd_data, e.d);
                check("gnt_cycle", cyc, e.c);
                check("ready_at_gnt", ready, 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 1000) begin
            tick();
            guard++;
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [31:0] d, input int c);
        exp_t e;
        e.g = g;
        e.d = d;
        e.c = c;
        sbq.push_back(e);
    endtask

    task automatic chk_reset(input string tag);
        @(negedge clk);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_rnd"}, rnd_data, 0);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_en"}, trng_en, 0);
        check({tag, "_hfail"}, health_fail, 0);
    endtask

    // Entered at cycle 0; requests are raised during warm-up and must be ignored.
    task automatic warmup();
        @(negedge clk);
        check("warm_en_c0", trng_en, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) req = 4'b1111;
            @(negedge clk);
            check("warm_en", trng_en, 1);
            check("warm_ready", ready, 0);
        end
        tick();
        req = 4'b0000;
        @(negedge clk);
        check("warm_done_en", trng_en, 0);
        check("warm_done_ready", ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        const_mode = 1'b0;
        tick();
        tick();
        chk_reset("rst");
        tick();
        rst = 1'b0;
        warmup();

        // Round robin between requesters 0 and 2.
        goto(6);
        req = 4'b0101;
        push(4'b0001, lfsr_n(6), 10);
        push(4'b0100, lfsr_n(8), 15);
        push(4'b0001, lfsr_n(10), 20);
        push(4'b0100, lfsr_n(12), 25);
        goto(26);
        req = 4'b0000;

        // Pointer wrap from 3 back to 0.
        goto(27);
        req = 4'b1000;
        push(4'b1000, lfsr_n(14), 31);
        goto(32);
        req = 4'b1001;
        push(4'b0001, lfsr_n(16), 36);
        goto(37);
        req = 4'b1000;
        push(4'b1000, lfsr_n(18), 41);
        goto(42);
        req = 4'b0000;

        // Requester 1 drops during GEN; its word is discarded and requester 2 is served next.
        goto(43);
        req = 4'b0010;
        goto(44);
        req = 4'b0100;
        push(4'b0100, lfsr_n(22), 52);
        goto(47);
        @(negedge clk);
        check("drop_no_gnt", gnt, 0);
        check("drop_rnd_hold", rnd_data, lfsr_n(18));
        goto(53);
        req = 4'b0000;

        // Reset while in GEN.
        goto(54);
        req = 4'b0001;
        goto(55);
        @(negedge clk);
        check("gen_en", trng_en, 1);
        rst = 1'b1;
        req = 4'b0000;
        tick();
        chk_reset("midrst");
        tick();
        rst = 1'b0;
        warmup();
        goto(6);
        req = 4'b1001;
        push(4'b0001, lfsr_n(6), 10);
        goto(11);
        req = 4'b0000;

        // Stuck TRNG output.
        goto(12);
        const_mode = 1'b1;
        req = 4'b0001;
        push(4'b0001, CONST, 16);
        push(4'b0001, CONST, 21);
        push(4'b0001, CONST, 26);
`ifdef TRNG_HEALTH_EN
        goto(26);
        @(negedge clk);
        check("hfail_before", health_fail, 0);
        goto(31);
        @(negedge clk);
        check("hfail_set", health_fail, 1);
        check("hfail_en", trng_en, 0);
        goto(40);
        @(negedge clk);
        check("hfail_sticky", health_fail, 1);
        check("hfail_park_en", trng_en, 0);
        req = 4'b0000;
`else
        push(4'b0001, CONST, 31);
        goto(32);
        req = 4'b0000;
        @(negedge clk);
        check("hfail_tied", health_fail, 0);
`endif

        goto(45);
        @(negedge clk);
        check("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
